// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t              - FSM state encoding (IDLE, LOAD_STALL)
//   CNT_W                - width of the load-use bubble counter
//   MAX_LOAD_USE_STALLS  - largest bubble count the counter can hold
package hazard_pkg;

    localparam int CNT_W               = 3;
    localparam int MAX_LOAD_USE_STALLS = 7;

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: free-running enable counter, wraps modulo 2^WIDTH.
//   clk      in   core clock, rising edge
//   reset_n  in   asynchronous active-low reset, clears count
//   en       in   increment this cycle
//   count    out  current count
module hazard_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubble insertion, taken-branch flush and
// data-memory freeze for the 5-stage core. Sits between ID and EX.
// Build option: define HAZARD_PERF_EN to enable the stall/flush counters;
// without it stall_cycles and flush_count are tied to zero.
//   clk, reset_n                 clock, asynchronous active-low reset
//   mem_re_E, rd_E               EX instruction is a load / its destination
//   rs1_D, rs2_D                 ID instruction source registers
//   rs1_used_D, rs2_used_D       ID instruction really reads rs1 / rs2
//   branch_taken_E               EX instruction redirects the PC
//   dmem_busy                    data memory access still pending
//   pc_write_en, ifid_write_en   PC / IF-ID may update
//   ifid_flush, idex_flush       clear IF-ID / bubble into ID-EX
//   freeze                       hold EX-MEM and MEM-WB
//   stall                        load-use stall active this cycle
//   stall_cycles, flush_count    performance counters
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int   NUM_REGS        = 32,
    parameter int   LOAD_USE_STALLS = 1,
    parameter int   PERF_W          = 32,
    localparam int  REG_AW          = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_re_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic              rs1_used_D,
    input  logic              rs2_used_D,
    input  logic              branch_taken_E,
    input  logic              dmem_busy,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              freeze,
    output logic              stall,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    generate
        if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
            LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > MAX_LOAD_USE_STALLS) begin : g_bad_params
            $error("hazard_control_unit: NUM_REGS must be a power of two and LOAD_USE_STALLS in 1..7");
        end
    endgenerate

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOAD_USE_STALLS - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             hazard_D;

    assign hazard_D = mem_re_E && (rd_E != '0) &&
                      ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Outputs are gated by reset_n so an asserted reset overrides every
    // input combinationally, not just at the next clock edge.
    always_comb begin
        next_state    = state;
        next_cnt      = cnt;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        freeze        = 1'b0;
        stall         = 1'b0;
        if (reset_n) begin
            if (dmem_busy) begin
                // Everything holds; a taken branch is re-presented next cycle.
                freeze        = 1'b1;
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
            end else if (branch_taken_E) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                next_state = IDLE;
                next_cnt   = '0;
            end else if (state == LOAD_STALL) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_flush    = 1'b1;
                stall         = 1'b1;
                next_cnt      = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = IDLE;
                end
            end else if (hazard_D) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_flush    = 1'b1;
                stall         = 1'b1;
                if (LOAD_USE_STALLS > 1) begin
                    next_state = LOAD_STALL;
                    next_cnt   = RELOAD;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_counter #(.WIDTH(PERF_W)) u_stall_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (stall),
        .count   (stall_cycles)
    );

    hazard_perf_counter #(.WIDTH(PERF_W)) u_flush_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ifid_flush),
        .count   (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with a single
// load-use bubble and one with three, driven from the same inputs.
// Output vectors are packed as {pc_we, ifid_we, ifid_flush, idex_flush, freeze, stall}.
module tb_hazard_control_unit;

    localparam logic [5:0] O_NORMAL = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000101;
    localparam logic [5:0] O_FREEZE = 6'b000010;
    localparam logic [5:0] O_FLUSH  = 6'b111100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mem_re_E;
    logic [4:0] rd_E, rs1_D, rs2_D;
    logic       rs1_used_D, rs2_used_D, branch_taken_E, dmem_busy;

    logic        pc1, ifid1, iff1, idf1, frz1, st1;
    logic        pc3, ifid3, iff3, idf3, frz3, st3;
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [5:0]  o1, o3;

    int checks = 0;
    int failures = 0;

    assign o1 = {pc1, ifid1, iff1, idf1, frz1, st1};
    assign o3 = {pc3, ifid3, iff3, idf3, frz3, st3};

    always #5 clk = ~clk;

    hazard_control_unit #(.NUM_REGS(32), .LOAD_USE_STALLS(1), .PERF_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem_re_E(mem_re_E), .rd_E(rd_E),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .branch_taken_E(branch_taken_E), .dmem_busy(dmem_busy),
        .pc_write_en(pc1), .ifid_write_en(ifid1), .ifid_flush(iff1), .idex_flush(idf1),
        .freeze(frz1), .stall(st1), .stall_cycles(sc1), .flush_count(fc1)
    );

    hazard_control_unit #(.NUM_REGS(32), .LOAD_USE_STALLS(3), .PERF_W(32)) dut3 (
        .clk(clk), .reset_n(reset_n), .mem_re_E(mem_re_E), .rd_E(rd_E),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .branch_taken_E(branch_taken_E), .dmem_busy(dmem_busy),
        .pc_write_en(pc3), .ifid_write_en(ifid3), .ifid_flush(iff3), .idex_flush(idf3),
        .freeze(frz3), .stall(st3), .stall_cycles(sc3), .flush_count(fc3)
    );

    // Advance to the next falling edge, apply inputs, settle 1 time unit.
    task automatic drive(input logic mre, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2,
                         input logic br, input logic busy);
        @(negedge clk);
        mem_re_E = mre; rd_E = rd; rs1_D = r1; rs2_D = r2;
        rs1_used_D = u1; rs2_used_D = u2; branch_taken_E = br; dmem_busy = busy;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        // Reset must override a busy, branching, hazard-laden input set.
        mem_re_E = 1; rd_E = 5; rs1_D = 5; rs2_D = 0; rs1_used_D = 1; rs2_used_D = 0;
        branch_taken_E = 1; dmem_busy = 1; reset_n = 0;
        #3;
        checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL reset_out1 got=%b exp=%b", o1, O_NORMAL); end
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL reset_out3 got=%b exp=%b", o3, O_NORMAL); end
        checks++; if (sc3 !== 32'd0 || fc3 !== 32'd0) begin failures++; $display("FAIL reset_ctr got=%0d/%0d exp=0/0", sc3, fc3); end
        @(negedge clk);
        mem_re_E = 0; branch_taken_E = 0; dmem_busy = 0; rs1_used_D = 0;
        reset_n = 1;
        #1;
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL post_reset got=%b exp=%b", o3, O_NORMAL); end
    endtask

    task automatic test_load_use_1();
        drive(1, 5, 5, 0, 1, 0, 0, 0);
        checks++; if (o1 !== O_STALL) begin failures++; $display("FAIL lu1_stall got=%b exp=%b", o1, O_STALL); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL lu1_after got=%b exp=%b", o1, O_NORMAL); end
        checks++; if (o3 !== O_STALL) begin failures++; $display("FAIL lu3_second got=%b exp=%b", o3, O_STALL); end
        idle(3);
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL lu3_drained got=%b exp=%b", o3, O_NORMAL); end
    endtask

    task automatic test_no_hazard();
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL x0_no_stall got=%b exp=%b", o1, O_NORMAL); end
        drive(1, 7, 3, 7, 1, 0, 0, 0);
        checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL rs2_unused got=%b exp=%b", o1, O_NORMAL); end
        drive(0, 7, 3, 7, 1, 1, 0, 0);
        checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL not_load got=%b exp=%b", o1, O_NORMAL); end
        drive(1, 7, 3, 7, 1, 1, 0, 0);
        checks++; if (o1 !== O_STALL) begin failures++; $display("FAIL rs2_used got=%b exp=%b", o1, O_STALL); end
        idle(3);
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL rs2_drained got=%b exp=%b", o3, O_NORMAL); end
    endtask

    task automatic test_busy_extend();
        logic [5:0] exp3 [5] = '{O_STALL, O_FREEZE, O_STALL, O_STALL, O_NORMAL};
        logic       busy [5] = '{0, 1, 0, 0, 0};
        logic       mre  [5] = '{1, 1, 1, 1, 0};
        for (int c = 0; c < 5; c++) begin
            drive(mre[c], 9, 9, 0, 1, 0, 0, busy[c]);
            checks++;
            if (o3 !== exp3[c]) begin
                failures++;
                $display("FAIL busy_extend cyc=%0d got=%b exp=%b", c, o3, exp3[c]);
            end
        end
    endtask

    task automatic test_branch_priority();
        drive(1, 4, 4, 0, 1, 0, 1, 0);
        checks++; if (o1 !== O_FLUSH) begin failures++; $display("FAIL br_hz1 got=%b exp=%b", o1, O_FLUSH); end
        checks++; if (o3 !== O_FLUSH) begin failures++; $display("FAIL br_hz3 got=%b exp=%b", o3, O_FLUSH); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL br_idle got=%b exp=%b", o3, O_NORMAL); end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (o3 !== O_FREEZE) begin failures++; $display("FAIL br_busy got=%b exp=%b", o3, O_FREEZE); end
        // Branch in the middle of a three-bubble stall cancels it.
        drive(1, 4, 4, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (o3 !== O_FLUSH) begin failures++; $display("FAIL br_in_stall got=%b exp=%b", o3, O_FLUSH); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL br_cancel got=%b exp=%b", o3, O_NORMAL); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 6, 0, 6, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o3 !== O_STALL) begin failures++; $display("FAIL mid_pre got=%b exp=%b", o3, O_STALL); end
        #1 reset_n = 0;
        #1;
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL mid_async got=%b exp=%b", o3, O_NORMAL); end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL mid_release got=%b exp=%b", o3, O_NORMAL); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL mid_idle got=%b exp=%b", o3, O_NORMAL); end
    endtask

    task automatic test_perf_counters();
        logic [31:0] es1, ef1, es3, ef3;
`ifdef HAZARD_PERF_EN
        es1 = 2; ef1 = 2; es3 = 4; ef3 = 2;
`else
        es1 = 0; ef1 = 0; es3 = 0; ef3 = 0;
`endif
        do_reset();
        drive(1, 8, 8, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 8, 8, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (sc3 !== es3) begin failures++; $display("FAIL perf_stall3 got=%0d exp=%0d", sc3, es3); end
        checks++; if (fc3 !== ef3) begin failures++; $display("FAIL perf_flush3 got=%0d exp=%0d", fc3, ef3); end
        checks++; if (sc1 !== es1) begin failures++; $display("FAIL perf_stall1 got=%0d exp=%0d", sc1, es1); end
        checks++; if (fc1 !== ef1) begin failures++; $display("FAIL perf_flush1 got=%0d exp=%0d", fc1, ef1); end
        do_reset();
        #1;
        checks++; if (sc3 !== 32'd0 || fc3 !== 32'd0) begin failures++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", sc3, fc3); end
    endtask

    initial begin
        test_reset();
        test_load_use_1();
        test_no_hazard();
        test_busy_extend();
        test_branch_priority();
        test_reset_mid_stall();
        test_perf_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
